// File: rtl/apogee_pkg.sv
// Shared types and default timing constants for the Apogee/RK86 timing block.
package apogee_pkg;

  // Reset sequencer states
  typedef enum logic [1:0] {
    SEQ_POR  = 2'd0,
    SEQ_HOLD = 2'd1,
    SEQ_RUN  = 2'd2
  } seq_state_t;

  // Apogee timing set (50 MHz system clock)
  localparam int unsigned APG_CPU_DIV  = 28;
  localparam int unsigned APG_TURBO_PH = 14;
  localparam int unsigned APG_F2_OFS   = 2;
  localparam int unsigned APG_PIT_PH   = 4;
  localparam int unsigned APG_PIX_DIV  = 6;
  localparam int unsigned APG_PIX2X_PH = 3;
  localparam int unsigned APG_PS2_DIV  = 3571;
  localparam int unsigned APG_INIT_CYC = 20000000;
  localparam int unsigned APG_RST_MIN  = 15;

  // RK86 timing set (50 MHz system clock)
  localparam int unsigned RK_CPU_DIV   = 32;
  localparam int unsigned RK_TURBO_PH  = 16;
  localparam int unsigned RK_F2_OFS    = 2;
  localparam int unsigned RK_PIT_PH    = 4;
  localparam int unsigned RK_PIX_DIV   = 6;
  localparam int unsigned RK_PIX2X_PH  = 3;
  localparam int unsigned RK_PS2_DIV   = 3571;
  localparam int unsigned RK_INIT_CYC  = 20000000;
  localparam int unsigned RK_RST_MIN   = 15;

  // Counter width for a modulus, never below one bit
  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/apogee_strobe_div.sv
// Free-running modulo-DIV counter with a registered one-cycle strobe on PH0
// and, when EN1 is set and ph1_en is high, also on PH1.
module apogee_strobe_div
  import apogee_pkg::*;
#(
  parameter int unsigned DIV = 2,
  parameter int unsigned PH0 = 0,
  parameter int unsigned PH1 = 0,
  parameter bit          EN1 = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ph1_en,
  output logic strobe
);

  localparam int unsigned CNT_W = cnt_width(DIV);

  logic [CNT_W-1:0] cnt;
  logic             hit_c;

  // Phase decode on the current count
  always_comb begin
    hit_c = (cnt == CNT_W'(PH0)) || (EN1 && ph1_en && (cnt == CNT_W'(PH1)));
  end

  // Counter wrap and strobe register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      cnt    <= (cnt == CNT_W'(DIV - 1)) ? '0 : cnt + CNT_W'(1);
      strobe <= hit_c;
    end
  end

endmodule

// File: rtl/apogee_sys_timing.sv
// Clock-enable generation and reset sequencing for the Apogee/RK86 cores.
module apogee_sys_timing
  import apogee_pkg::*;
#(
  parameter int unsigned CPU_DIV  = APG_CPU_DIV,
  parameter int unsigned TURBO_PH = APG_TURBO_PH,
  parameter int unsigned F2_OFS   = APG_F2_OFS,
  parameter int unsigned PIT_PH   = APG_PIT_PH,
  parameter int unsigned PIX_DIV  = APG_PIX_DIV,
  parameter int unsigned PIX2X_PH = APG_PIX2X_PH,
  parameter int unsigned PS2_DIV  = APG_PS2_DIV,
  parameter int unsigned INIT_CYC = APG_INIT_CYC,
  parameter int unsigned RST_MIN  = APG_RST_MIN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic turbo_req,
  input  logic rst_req,
  input  logic hold,
  input  logic cpu_a15,
  output logic ce_f1,
  output logic ce_f2,
  output logic ce_pit,
  output logic ce_dma,
  output logic ce_pix,
  output logic ce_pix2x,
  output logic ce_ps2,
  output logic clk_io,
  output logic turbo_act,
  output logic sys_reset,
  output logic startup
);

  localparam int unsigned POR_W = cnt_width(INIT_CYC + 1);
  localparam int unsigned RST_W = cnt_width(RST_MIN);

  seq_state_t       state, state_nxt;
  logic [POR_W-1:0] por_cnt, por_nxt;
  logic [RST_W-1:0] rst_cnt, rst_nxt;
  logic             cpu_wrap;

  // CPU chain: all instances share modulus and reset, so they run in lockstep
  apogee_strobe_div #(.DIV(CPU_DIV), .PH0(0), .PH1(TURBO_PH), .EN1(1'b1)) u_f1 (
    .clk(clk), .reset_n(reset_n), .ph1_en(turbo_act), .strobe(ce_f1));
  apogee_strobe_div #(.DIV(CPU_DIV), .PH0(F2_OFS), .PH1(TURBO_PH + F2_OFS), .EN1(1'b1)) u_f2 (
    .clk(clk), .reset_n(reset_n), .ph1_en(turbo_act), .strobe(ce_f2));
  apogee_strobe_div #(.DIV(CPU_DIV), .PH0(PIT_PH), .PH1(0), .EN1(1'b0)) u_pit (
    .clk(clk), .reset_n(reset_n), .ph1_en(1'b0), .strobe(ce_pit));
  // Decoding DIV-2 yields a strobe that is high exactly while the count is DIV-1
  apogee_strobe_div #(.DIV(CPU_DIV), .PH0(CPU_DIV - 2), .PH1(0), .EN1(1'b0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .ph1_en(1'b0), .strobe(cpu_wrap));

  // Pixel and PS/2 chains
  apogee_strobe_div #(.DIV(PIX_DIV), .PH0(0), .PH1(0), .EN1(1'b0)) u_pix (
    .clk(clk), .reset_n(reset_n), .ph1_en(1'b0), .strobe(ce_pix));
  apogee_strobe_div #(.DIV(PIX_DIV), .PH0(0), .PH1(PIX2X_PH), .EN1(1'b1)) u_pix2x (
    .clk(clk), .reset_n(reset_n), .ph1_en(1'b1), .strobe(ce_pix2x));
  apogee_strobe_div #(.DIV(PS2_DIV), .PH0(0), .PH1(0), .EN1(1'b0)) u_ps2 (
    .clk(clk), .reset_n(reset_n), .ph1_en(1'b0), .strobe(ce_ps2));

  assign ce_dma = ce_pit;

  // Sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= SEQ_POR;
      por_cnt <= POR_W'(INIT_CYC);
      rst_cnt <= '0;
    end else begin
      state   <= state_nxt;
      por_cnt <= por_nxt;
      rst_cnt <= rst_nxt;
    end
  end

  // Sequencer next state: POR countdown, then RST_MIN quiet clocks before RUN
  always_comb begin
    state_nxt = state;
    por_nxt   = por_cnt;
    rst_nxt   = rst_cnt;
    case (state)
      SEQ_POR: begin
        if (por_cnt == '0) begin
          state_nxt = SEQ_HOLD;
          rst_nxt   = '0;
        end else if (!hold) begin
          por_nxt = por_cnt - POR_W'(1);
        end
      end
      SEQ_HOLD: begin
        if (rst_req || hold) begin
          rst_nxt = '0;
        end else if (rst_cnt == RST_W'(RST_MIN - 1)) begin
          state_nxt = SEQ_RUN;
        end else begin
          rst_nxt = rst_cnt + RST_W'(1);
        end
      end
      SEQ_RUN: begin
        if (rst_req || hold) begin
          state_nxt = SEQ_HOLD;
          rst_nxt   = '0;
        end
      end
      default: begin
        state_nxt = SEQ_POR;
        por_nxt   = POR_W'(INIT_CYC);
        rst_nxt   = '0;
      end
    endcase
  end

  // Registered reset, startup overlay, turbo latch and I/O clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sys_reset <= 1'b1;
      startup   <= 1'b1;
      turbo_act <= 1'b0;
      clk_io    <= 1'b0;
    end else begin
      sys_reset <= (state_nxt != SEQ_RUN);
      startup   <= sys_reset | (startup & ~cpu_a15);
      clk_io    <= ~clk_io;
      if (cpu_wrap) turbo_act <= turbo_req;
    end
  end

endmodule

// File: tb/tb_apogee_sys_timing.sv
// Self-checking bench for apogee_sys_timing with a cycle-level reference model.
module tb_apogee_sys_timing;
  import apogee_pkg::*;

  localparam int unsigned CPU_DIV  = APG_CPU_DIV;
  localparam int unsigned TURBO_PH = APG_TURBO_PH;
  localparam int unsigned F2_OFS   = APG_F2_OFS;
  localparam int unsigned PIT_PH   = APG_PIT_PH;
  localparam int unsigned PIX_DIV  = APG_PIX_DIV;
  localparam int unsigned PIX2X_PH = APG_PIX2X_PH;
  localparam int unsigned PS2_DIV  = 37;
  localparam int unsigned INIT_CYC = 100;
  localparam int unsigned RST_MIN  = APG_RST_MIN;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic turbo_req = 1'b0, rst_req = 1'b0, hold = 1'b0, cpu_a15 = 1'b0;
  logic ce_f1, ce_f2, ce_pit, ce_dma, ce_pix, ce_pix2x, ce_ps2;
  logic clk_io, turbo_act, sys_reset, startup;
  logic [10:0] dut_vec;

  apogee_sys_timing #(
    .CPU_DIV(CPU_DIV), .TURBO_PH(TURBO_PH), .F2_OFS(F2_OFS), .PIT_PH(PIT_PH),
    .PIX_DIV(PIX_DIV), .PIX2X_PH(PIX2X_PH), .PS2_DIV(PS2_DIV),
    .INIT_CYC(INIT_CYC), .RST_MIN(RST_MIN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .turbo_req(turbo_req), .rst_req(rst_req),
    .hold(hold), .cpu_a15(cpu_a15), .ce_f1(ce_f1), .ce_f2(ce_f2),
    .ce_pit(ce_pit), .ce_dma(ce_dma), .ce_pix(ce_pix), .ce_pix2x(ce_pix2x),
    .ce_ps2(ce_ps2), .clk_io(clk_io), .turbo_act(turbo_act),
    .sys_reset(sys_reset), .startup(startup)
  );

  assign dut_vec = {ce_f1, ce_f2, ce_pit, ce_dma, ce_pix, ce_pix2x, ce_ps2,
                    clk_io, turbo_act, sys_reset, startup};

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: everything derived from edge count since reset release
  int          e;
  int          por_left;
  bit          por_done;
  int          quiet;
  bit          m_tact, m_sys_reset, m_startup;
  logic [10:0] m_exp;

  typedef struct {
    string name;
    bit    turbo, req, hld, a15;
    int    n;
    bit    exp_rst, exp_st;
  } seg_t;
  seg_t segs[$];

  function void add_seg(input string nm, input bit t, input bit r, input bit h,
                        input bit a, input int n, input bit er, input bit es);
    seg_t s;
    s.name = nm; s.turbo = t; s.req = r; s.hld = h; s.a15 = a;
    s.n = n; s.exp_rst = er; s.exp_st = es;
    segs.push_back(s);
  endfunction

  function void model_reset();
    e = 0; por_left = int'(INIT_CYC); por_done = 1'b0; quiet = 0;
    m_tact = 1'b0; m_sys_reset = 1'b1; m_startup = 1'b1;
    m_exp = 11'b000_0000_0011;
  endfunction

  function void model_edge();
    int  c, p, s;
    bit  f1, f2, pit, pix, pix2x, ps2, io, new_st;
    c = e % int'(CPU_DIV);
    p = e % int'(PIX_DIV);
    s = e % int'(PS2_DIV);
    f1    = (c == 0) || (m_tact && c == int'(TURBO_PH));
    f2    = (c == int'(F2_OFS)) || (m_tact && c == int'(TURBO_PH + F2_OFS));
    pit   = (c == int'(PIT_PH));
    pix   = (p == 0);
    pix2x = (p == 0) || (p == int'(PIX2X_PH));
    ps2   = (s == 0);
    io    = ((e % 2) == 0);
    if (c == int'(CPU_DIV) - 1) m_tact = turbo_req;
    new_st = m_sys_reset | (m_startup & ~cpu_a15);
    // Released once POR is exhausted and RST_MIN consecutive quiet clocks follow
    if (!por_done) begin
      if (por_left == 0) begin
        por_done = 1'b1;
        quiet = 0;
      end else if (!hold) begin
        por_left--;
      end
    end else if (rst_req || hold) begin
      quiet = 0;
    end else if (quiet < int'(RST_MIN)) begin
      quiet++;
    end
    m_sys_reset = !(por_done && quiet >= int'(RST_MIN));
    m_startup = new_st;
    e++;
    m_exp = {f1, f2, pit, pit, pix, pix2x, ps2, io, m_tact, m_sys_reset, m_startup};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: model and DUT advance together, compare shortly after the edge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle", int'(dut_vec), int'(m_exp));
    @(negedge clk);
  endtask

  task automatic measure(input int ncyc, output int nf1, output int nf2,
                         output int npit, output int gap, output int lag);
    int k, first_f1, first_f2;
    nf1 = 0; nf2 = 0; npit = 0; gap = -1; lag = -99;
    first_f1 = -1; first_f2 = -1;
    for (k = 1; k <= ncyc; k++) begin
      cycle();
      if (ce_f1) begin
        if (first_f1 < 0) first_f1 = k;
        else if (gap < 0) gap = k - first_f1;
        nf1++;
      end
      if (ce_f2) begin
        if (first_f2 < 0) first_f2 = k;
        nf2++;
      end
      if (ce_pit) npit++;
    end
    if (first_f1 >= 0 && first_f2 >= 0) lag = first_f2 - first_f1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int nf1, nf2, npit, gap, lag, guard;

    // name, turbo, rst_req, hold, a15, cycles, exp sys_reset, exp startup
    add_seg("por_run",        0, 0, 0, 0,  50, 1, 1);
    add_seg("por_frozen",     0, 0, 1, 0, 500, 1, 1);
    add_seg("por_finish",     0, 0, 0, 0,  65, 1, 1);
    add_seg("por_release",    0, 0, 0, 0,   1, 0, 1);
    add_seg("startup_kept",   0, 0, 0, 0,  20, 0, 1);
    add_seg("startup_clear",  0, 0, 0, 1,   1, 0, 0);
    add_seg("startup_stays0", 0, 0, 0, 0,  10, 0, 0);
    add_seg("req_rise",       0, 1, 0, 0,   1, 1, 0);
    add_seg("req_held",       0, 1, 0, 0,   2, 1, 1);
    add_seg("req_min_wait",   0, 0, 0, 0,  14, 1, 1);
    add_seg("req_release",    0, 0, 0, 0,   1, 0, 1);
    add_seg("clear_again",    0, 0, 0, 1,   1, 0, 0);
    add_seg("req_and_hold",   0, 1, 1, 0,   5, 1, 1);
    add_seg("hold_only",      0, 0, 1, 0,   5, 1, 1);
    add_seg("req_only",       0, 1, 0, 0,   3, 1, 1);
    add_seg("both_min_wait",  0, 0, 0, 0,  14, 1, 1);
    add_seg("both_release",   0, 0, 0, 0,   1, 0, 1);

    repeat (3) @(negedge clk);
    model_reset();
    check("reset_state", int'(dut_vec), int'(11'b000_0000_0011));
    reset_n = 1'b1;

    // Table-driven reset/startup sequence
    foreach (segs[i]) begin
      turbo_req = segs[i].turbo; rst_req = segs[i].req;
      hold = segs[i].hld; cpu_a15 = segs[i].a15;
      repeat (segs[i].n) cycle();
      check({segs[i].name, "_sys_reset"}, int'(sys_reset), int'(segs[i].exp_rst));
      check({segs[i].name, "_startup"}, int'(startup), int'(segs[i].exp_st));
    end
    rst_req = 1'b0; hold = 1'b0; cpu_a15 = 1'b0;

    // Normal-mode phase relations, aligned to counter 0
    guard = 0;
    while ((e % int'(CPU_DIV)) != 0 && guard < 64) begin cycle(); guard++; end
    measure(2 * int'(CPU_DIV), nf1, nf2, npit, gap, lag);
    check("f1_count_normal", nf1, 2);
    check("f1_period_normal", gap, int'(CPU_DIV));
    check("f2_lag", lag, int'(F2_OFS));
    check("pit_count_normal", npit, 2);

    // Turbo raised mid-period takes effect only from the next period
    guard = 0;
    while ((e % int'(CPU_DIV)) != 10 && guard < 64) begin cycle(); guard++; end
    turbo_req = 1'b1;
    measure(int'(CPU_DIV) - 10, nf1, nf2, npit, gap, lag);
    check("no_mid_period_turbo_f1", nf1, 0);
    measure(int'(CPU_DIV), nf1, nf2, npit, gap, lag);
    check("turbo_f1_count", nf1, 2);
    check("turbo_f1_spacing", gap, int'(TURBO_PH));
    check("turbo_f2_count", nf2, 2);
    check("turbo_pit_count", npit, 1);
    check("turbo_act_on", int'(turbo_act), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) turbo_req = ~turbo_req;
      rst_req = ($urandom_range(0, 79) < 2);
      if ($urandom_range(0, 199) == 0) hold = ~hold;
      cpu_a15 = ($urandom_range(0, 3) == 0);
      cycle();
    end

    // Asynchronous reset mid-period while in turbo
    rst_req = 1'b0; hold = 1'b0; cpu_a15 = 1'b0; turbo_req = 1'b1;
    repeat (3 * int'(CPU_DIV)) cycle();
    check("turbo_before_async", int'(turbo_act), 1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check("async_reset_outputs", int'(dut_vec), int'(11'b000_0000_0011));
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    repeat (INIT_CYC + RST_MIN) cycle();
    check("por_restart_held", int'(sys_reset), 1);
    cycle();
    check("por_restart_release", int'(sys_reset), 0);
    check("por_restart_startup", int'(startup), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apogee_sys_timing.md
Name: apogee_sys_timing

Overview:
Parametrised clock-enable and reset controller for the Apogee/RK86 family cores. It replaces the ad-hoc divider and reset logic in the top level with one block. From the single system clock it generates every clock-enable strobe the design needs:
- CPU phases F1/F2, with turbo
- PIT/DMA tick
- pixel and 2x pixel
- PS/2 sampling tick
- half-rate I/O clock

It also sequences power-on and user reset and maintains the boot-ROM "startup" overlay flag.

Parameters:
CPU_DIV, 28, system clocks per CPU phase period (F1/F2/PIT), ≥ 2*F2_OFS+2
TURBO_PH, 14, counter value of the extra F1 in turbo; F2 extra at TURBO_PH+F2_OFS
F2_OFS, 2, F2 strobe offset after F1
PIT_PH, 4, counter value producing ce_pit/ce_dma
PIX_DIV, 6, system clocks per pixel
PIX2X_PH, 3, second ce_pix2x phase within pixel period
PS2_DIV, 3571, system clocks per ce_ps2
INIT_CYC, 20000000, power-on hold length in clocks
RST_MIN, 15, minimum asserted reset length in clocks after request release

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous, active-low reset
turbo_req  in  1  requested turbo mode (level, from status)
rst_req  in  1  user/OSD/key reset request (level, active-high)
hold  in  1  download in progress; freezes power-on count and holds sys_reset
cpu_a15  in  1  CPU address bit 15, for startup clear
ce_f1  out  1  CPU F1 strobe
ce_f2  out  1  CPU F2 strobe
ce_pit  out  1  PIT tick strobe
ce_dma  out  1  DMA tick strobe (identical to ce_pit)
ce_pix  out  1  pixel strobe
ce_pix2x  out  1  scandoubler strobe
ce_ps2  out  1  PS/2 host tick
clk_io  out  1  clk/2 toggle
turbo_act  out  1  turbo mode in effect
sys_reset  out  1  active-high system reset
startup  out  1  boot-ROM overlay active

Behaviour:
Reset values (reset_n=0): all counters 0, all ce_* 0, clk_io 0, turbo_act 0, sys_reset 1, startup 1, sequencer state POR with its count loaded to INIT_CYC.

Strobes:
- All strobes are registered; each is high for exactly one clk, in the cycle after the counter holds the decode value.
- cpu_cnt counts 0..CPU_DIV-1 and wraps.
- turbo_act is reloaded from turbo_req only in the wrap cycle (cpu_cnt==CPU_DIV-1), so it never changes mid-period.
- ce_f1 = (cpu_cnt==0) | (turbo_act & cpu_cnt==TURBO_PH).
- ce_f2 = (cpu_cnt==F2_OFS) | (turbo_act & cpu_cnt==TURBO_PH+F2_OFS).
- ce_pit = ce_dma = (cpu_cnt==PIT_PH); this tick is unaffected by turbo.
- pix_cnt counts 0..PIX_DIV-1; ce_pix = (pix_cnt==0); ce_pix2x = (pix_cnt==0)|(pix_cnt==PIX2X_PH).
- ps2_cnt counts 0..PS2_DIV-1; ce_ps2 = (ps2_cnt==0).
- clk_io toggles every clk.
- Counter widths are $clog2 of the divisor. Counters free-run and are not cleared by sys_reset.

Reset sequencer, states POR, HOLD, RUN:
- POR: sys_reset=1. Count decrements each clk when hold=0 and freezes when hold=1. At count 0 go to HOLD with rst_cnt=0.
- HOLD: sys_reset=1. rst_cnt increments while rst_req=0 and hold=0, saturating at RST_MIN-1. If rst_req=1 or hold=1, rst_cnt resets to 0. When rst_cnt==RST_MIN-1 with rst_req=0 and hold=0, go to RUN.
- RUN: sys_reset=0. Any rst_req=1 or hold=1 returns to HOLD next clk with rst_cnt=0.
- Simultaneous events: rst_req and hold together simply keep HOLD. Release happens only after both have been low for RST_MIN consecutive clks.

Startup flag:
- Next value = sys_reset | (startup & ~cpu_a15).
- It is set throughout reset and cleared on the first clk with cpu_a15=1 while sys_reset=0.

Decomposition:
- Shared package apogee_pkg: sequencer state enum (POR/HOLD/RUN) and default divisor constants for the Apogee and RK86 timing sets. These defaults are reused by the top level and by the bench.
- One sub-module, apogee_strobe_div: a parametrised modulo counter (params DIV, PH0, PH1, EN1) producing a registered one-cycle strobe on either phase. It is instantiated for the cpu, pix and ps2 chains.

Test Plan:
1. Bench params INIT_CYC=100, RST_MIN=15, turbo_req=0, no requests. Required: sys_reset stays 1 for 100+15 (±1) clks after reset_n rises, then 0. ce_f1 has period 28 clks; ce_f2 follows ce_f1 by exactly 2 clks.
2. Raise turbo_req mid-period at cpu_cnt=10. Required: no extra ce_f1 at cnt 14 in that period. From the next period, ce_f1 occurs at cnt 0 and 14 (spacing 14) and ce_pit stays at period 28.
3. In RUN, pulse rst_req for 3 clks. Required: sys_reset rises 1 clk after rst_req rises and falls exactly 15 clks after rst_req falls. startup=1 throughout reset.
4. Hold hold=1 for 500 clks starting at POR count 50. Required: count freezes. sys_reset deasserts 50+15 clks after hold falls, not earlier.
5. After reset release, drive cpu_a15=0 for 20 clks, then 1. Required: startup stays 1, clears the clk after cpu_a15=1, and stays 0 when cpu_a15 returns to 0.
6. Assert reset_n=0 asynchronously mid-period while in turbo. Required: all ce_* are 0 and turbo_act=0 immediately; sys_reset=1 and startup=1; POR restarts with the full INIT_CYC count.
